// File: rtl/pulse_transmitter_timer_pkg.sv
// Shared types and width helpers for the multi-channel pulse transmitter timer.
// Readback option: PULSE_TRANSMITTER_TIMER_READBACK_EN.
package pulse_transmitter_timer_pkg;

   typedef enum logic [1:0] {
      TMR_IDLE = 2'd0,
      TMR_RUN  = 2'd1,
      TMR_DONE = 2'd2
   } tmr_state_t;

   // The prescaler field holds a shift of 0 .. PRESCALER_WIDTH-1.
   function automatic int calc_psw(input int prescaler_width);
      return (prescaler_width > 1) ? $clog2(prescaler_width) : 1;
   endfunction

   // Counter width: (2^TW) << (PRESCALER_WIDTH-1) - 1 always fits.
   function automatic int calc_cw(input int timer_width, input int prescaler_width);
      return timer_width + prescaler_width;
   endfunction

   function automatic int calc_selw(input int num_channels);
      return (num_channels > 1) ? $clog2(num_channels) : 1;
   endfunction

endpackage

// File: rtl/pulse_transmitter_multi_timer_if.sv
// Bundle of per-channel control/status buses for the multi-channel timer.
// PULSE_TRANSMITTER_TIMER_READBACK_EN adds rd_sel / rd_count.
interface pulse_transmitter_multi_timer_if
   import pulse_transmitter_timer_pkg::*;
#(
   parameter int NUM_CHANNELS    = 4,
   parameter int PRESCALER_WIDTH = 16,
   parameter int TIMER_WIDTH     = 8
) ();
   localparam int PSW = calc_psw(PRESCALER_WIDTH);

   logic [NUM_CHANNELS-1:0]             en;
   logic [NUM_CHANNELS-1:0]             one_shot;
   logic [NUM_CHANNELS-1:0]             restart;
   logic [NUM_CHANNELS*PSW-1:0]         prescaler;
   logic [NUM_CHANNELS*TIMER_WIDTH-1:0] duration;
   logic [NUM_CHANNELS-1:0]             pulse_out;
   logic [NUM_CHANNELS-1:0]             busy;
   logic [NUM_CHANNELS-1:0]             done;

`ifdef PULSE_TRANSMITTER_TIMER_READBACK_EN
   localparam int CW   = calc_cw(TIMER_WIDTH, PRESCALER_WIDTH);
   localparam int SELW = calc_selw(NUM_CHANNELS);
   logic [SELW-1:0] rd_sel;
   logic [CW-1:0]   rd_count;

   modport master (output en, one_shot, restart, prescaler, duration, rd_sel,
                   input  pulse_out, busy, done, rd_count);
   modport slave  (input  en, one_shot, restart, prescaler, duration, rd_sel,
                   output pulse_out, busy, done, rd_count);
`else
   modport master (output en, one_shot, restart, prescaler, duration,
                   input  pulse_out, busy, done);
   modport slave  (input  en, one_shot, restart, prescaler, duration,
                   output pulse_out, busy, done);
`endif
endinterface

// File: rtl/pulse_transmitter_timer_channel.sv
// One countdown timer channel: IDLE/RUN/DONE FSM, counter and load computation.
// PULSE_TRANSMITTER_TIMER_READBACK_EN exposes the live counter.
module pulse_transmitter_timer_channel
   import pulse_transmitter_timer_pkg::*;
#(
   parameter int PRESCALER_WIDTH = 16,
   parameter int TIMER_WIDTH     = 8,
   localparam int PSW = calc_psw(PRESCALER_WIDTH),
   localparam int CW  = calc_cw(TIMER_WIDTH, PRESCALER_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_en,
   input  logic                   i_one_shot,
   input  logic                   i_restart,
   input  logic [PSW-1:0]         i_prescaler,
   input  logic [TIMER_WIDTH-1:0] i_duration,
   output logic                   o_pulse,
   output logic                   o_busy,
   output logic                   o_done
`ifdef PULSE_TRANSMITTER_TIMER_READBACK_EN
   ,
   output logic [CW-1:0]          o_count
`endif
);
   tmr_state_t    r_state;
   logic [CW-1:0] r_count;
   logic          r_pulse;
   logic          r_busy;
   logic          r_done;
   logic [CW-1:0] w_load;

   assign w_load = ((CW'(i_duration) + CW'(1)) << i_prescaler) - CW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= TMR_IDLE;
         r_count <= '0;
         r_pulse <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_pulse <= 1'b0;
         case (r_state)
            TMR_IDLE: begin
               if (i_en) begin
                  r_state <= TMR_RUN;
                  r_count <= w_load;
                  r_busy  <= 1'b1;
               end
            end
            TMR_RUN: begin
               // Disable beats restart, restart beats expiry.
               if (!i_en) begin
                  r_state <= TMR_IDLE;
                  r_count <= '0;
                  r_busy  <= 1'b0;
               end else if (i_restart) begin
                  r_count <= w_load;
               end else if (r_count != '0) begin
                  r_count <= r_count - CW'(1);
               end else begin
                  r_pulse <= 1'b1;
                  if (i_one_shot) begin
                     r_state <= TMR_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_count <= w_load;
                  end
               end
            end
            TMR_DONE: begin
               if (!i_en) begin
                  r_state <= TMR_IDLE;
                  r_done  <= 1'b0;
               end else if (i_restart) begin
                  r_state <= TMR_RUN;
                  r_count <= w_load;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            default: begin
               r_state <= TMR_IDLE;
               r_count <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign o_pulse = r_pulse;
   assign o_busy  = r_busy;
   assign o_done  = r_done;
`ifdef PULSE_TRANSMITTER_TIMER_READBACK_EN
   assign o_count = r_count;
`endif
endmodule

// File: rtl/pulse_transmitter_multi_timer.sv
// NUM_CHANNELS independent countdown timers with a registered 1-cycle tick each.
// PULSE_TRANSMITTER_TIMER_READBACK_EN adds a selectable live-counter readback.
module pulse_transmitter_multi_timer
   import pulse_transmitter_timer_pkg::*;
#(
   parameter int NUM_CHANNELS    = 4,
   parameter int PRESCALER_WIDTH = 16,
   parameter int TIMER_WIDTH     = 8
) (
   input  logic clk,
   input  logic sys_rst,
   pulse_transmitter_multi_timer_if.slave bus
);
   localparam int PSW = calc_psw(PRESCALER_WIDTH);

`ifdef PULSE_TRANSMITTER_TIMER_READBACK_EN
   localparam int CW = calc_cw(TIMER_WIDTH, PRESCALER_WIDTH);
   logic [CW-1:0] w_count [NUM_CHANNELS];
`endif

   generate
      for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
         pulse_transmitter_timer_channel #(
            .PRESCALER_WIDTH (PRESCALER_WIDTH),
            .TIMER_WIDTH     (TIMER_WIDTH)
         ) u_ch (
            .clk         (clk),
            .rst         (sys_rst),
            .i_en        (bus.en[gi]),
            .i_one_shot  (bus.one_shot[gi]),
            .i_restart   (bus.restart[gi]),
            .i_prescaler (bus.prescaler[gi*PSW +: PSW]),
            .i_duration  (bus.duration[gi*TIMER_WIDTH +: TIMER_WIDTH]),
            .o_pulse     (bus.pulse_out[gi]),
            .o_busy      (bus.busy[gi]),
            .o_done      (bus.done[gi])
`ifdef PULSE_TRANSMITTER_TIMER_READBACK_EN
            ,
            .o_count     (w_count[gi])
`endif
         );
      end
   endgenerate

`ifdef PULSE_TRANSMITTER_TIMER_READBACK_EN
   // Out-of-range selects match no channel and read back zero.
   always_comb begin
      bus.rd_count = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (int'(bus.rd_sel) == i) bus.rd_count = w_count[i];
      end
   end
`endif
endmodule

// File: tb/tb_pulse_transmitter_multi_timer.sv
// Bench for pulse_transmitter_multi_timer: directed scenarios then random traffic,
// compared against an absolute-time tick model. Honours PULSE_TRANSMITTER_TIMER_READBACK_EN.
module tb_pulse_transmitter_multi_timer;
   localparam int NC  = 4;
   localparam int PW  = 16;
   localparam int TW  = 8;
   localparam int PSW = 4;

   logic clk = 1'b0;
   logic sys_rst;
   always #5 clk = ~clk;

   pulse_transmitter_multi_timer_if #(.NUM_CHANNELS(NC), .PRESCALER_WIDTH(PW), .TIMER_WIDTH(TW)) bus ();

   pulse_transmitter_multi_timer #(.NUM_CHANNELS(NC), .PRESCALER_WIDTH(PW), .TIMER_WIDTH(TW)) dut (
      .clk     (clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   // Model: each running channel remembers the absolute edge number of its next tick.
   longint   cyc = 0;
   int       m_state [NC];   // 0 stopped, 1 running, 2 expired
   longint   m_next  [NC];
   logic [NC-1:0] m_pulse;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, cyc);
      end
   endtask

   function automatic longint period(input int ch);
      return (longint'(bus.duration[ch*TW +: TW]) + 1) << bus.prescaler[ch*PSW +: PSW];
   endfunction

   function automatic logic [31:0] m_count(input int ch);
      if (m_state[ch] == 1) return 32'(m_next[ch] - cyc - 1);
      return 32'd0;
   endfunction

   task automatic model_edge();
      for (int i = 0; i < NC; i++) begin
         m_pulse[i] = 1'b0;
         case (m_state[i])
            0: if (bus.en[i]) begin m_state[i] = 1; m_next[i] = cyc + period(i); end
            1: begin
               if (!bus.en[i]) m_state[i] = 0;
               else if (bus.restart[i]) m_next[i] = cyc + period(i);
               else if (cyc == m_next[i]) begin
                  m_pulse[i] = 1'b1;
                  if (bus.one_shot[i]) m_state[i] = 2;
                  else m_next[i] = cyc + period(i);
               end
            end
            default: begin
               if (!bus.en[i]) m_state[i] = 0;
               else if (bus.restart[i]) begin m_state[i] = 1; m_next[i] = cyc + period(i); end
            end
         endcase
      end
   endtask

   task automatic check_all();
      logic [NC-1:0] exp_busy, exp_done;
      for (int i = 0; i < NC; i++) begin
         exp_busy[i] = (m_state[i] == 1);
         exp_done[i] = (m_state[i] == 2);
      end
      chk("pulse_out", 32'(bus.pulse_out), 32'(m_pulse));
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("done", 32'(bus.done), 32'(exp_done));
`ifdef PULSE_TRANSMITTER_TIMER_READBACK_EN
      chk("rd_count", 32'(bus.rd_count), m_count(int'(bus.rd_sel)));
`endif
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      check_all();
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic cfg(input int ch, input int d, input int p, input logic os);
      bus.duration[ch*TW +: TW]   = TW'(d);
      bus.prescaler[ch*PSW +: PSW] = PSW'(p);
      bus.one_shot[ch]            = os;
   endtask

   task automatic strobe_restart(input int ch);
      bus.restart[ch] = 1'b1;
      step();
      bus.restart[ch] = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NC; i++) begin m_state[i] = 0; m_next[i] = 0; end
      m_pulse = '0;
   endtask

   initial begin
      sys_rst = 1'b1;
      bus.en = '0; bus.one_shot = '0; bus.restart = '0;
      bus.prescaler = '0; bus.duration = '0;
`ifdef PULSE_TRANSMITTER_TIMER_READBACK_EN
      bus.rd_sel = '0;
`endif
      model_reset();
      repeat (2) @(posedge clk);
      cyc = 2;
      #1;
      check_all();
      sys_rst = 1'b0;

      // Repeat channel d=3,p=0: ticks every 4 edges.
      cfg(0, 3, 0, 1'b0);
      bus.en[0] = 1'b1;
      step();
      steps(3);
      chk("t1_no_tick_e3", 32'(bus.pulse_out[0]), 32'd0);
      step();
      chk("t1_tick_e4", 32'(bus.pulse_out[0]), 32'd1);
      steps(4);
      chk("t1_tick_e8", 32'(bus.pulse_out[0]), 32'd1);
      chk("t1_busy", 32'(bus.busy[0]), 32'd1);

      // Restart lands on the expiry edge: no tick, full reload.
`ifdef PULSE_TRANSMITTER_TIMER_READBACK_EN
      bus.rd_sel = 2'd0;
`endif
      steps(3);
      strobe_restart(0);
      chk("t6_no_tick", 32'(bus.pulse_out[0]), 32'd0);
`ifdef PULSE_TRANSMITTER_TIMER_READBACK_EN
      chk("t6_reload", 32'(bus.rd_count), 32'd3);
`endif
      steps(4);
      chk("t6_tick_after", 32'(bus.pulse_out[0]), 32'd1);
      bus.en[0] = 1'b0;
      step();

      // One-shot d=1,p=2: single tick after 8 edges, then restart.
      cfg(1, 1, 2, 1'b1);
      bus.en[1] = 1'b1;
      step();
      steps(7);
      step();
      chk("t2_tick", 32'(bus.pulse_out[1]), 32'd1);
      chk("t2_done", 32'(bus.done[1]), 32'd1);
      steps(5);
      strobe_restart(1);
      steps(7);
      step();
      chk("t2_restart_tick", 32'(bus.pulse_out[1]), 32'd1);
      bus.en[1] = 1'b0;
      step();

      // d=0,p=0: pulse_out held high while running.
      cfg(2, 0, 0, 1'b0);
      bus.en[2] = 1'b1;
`ifdef PULSE_TRANSMITTER_TIMER_READBACK_EN
      bus.rd_sel = 2'd2;
`endif
      step();
      steps(3);
      chk("t3_cont_pulse", 32'(bus.pulse_out[2]), 32'd1);
      bus.en[2] = 1'b0;
      step();
      chk("t3_off_pulse", 32'(bus.pulse_out[2]), 32'd0);
      chk("t3_off_busy", 32'(bus.busy[2]), 32'd0);

      // Maximum load value.
      cfg(3, 255, 15, 1'b0);
      bus.en[3] = 1'b1;
`ifdef PULSE_TRANSMITTER_TIMER_READBACK_EN
      bus.rd_sel = 2'd3;
`endif
      step();
`ifdef PULSE_TRANSMITTER_TIMER_READBACK_EN
      chk("t4_max_load", 32'(bus.rd_count), 32'h7F_FFFF);
`endif
      steps(20);
      chk("t4_max_busy", 32'(bus.busy[3]), 32'd1);
      bus.en[3] = 1'b0;
      step();

      // Mid-count duration change applies at the next reload: 12 then 4.
      cfg(3, 5, 1, 1'b0);
      bus.en[3] = 1'b1;
      step();
      for (int k = 1; k <= 12; k++) begin
         if (k == 4) cfg(3, 1, 1, 1'b0);
         step();
      end
      chk("t4_tick_12", 32'(bus.pulse_out[3]), 32'd1);
      steps(4);
      chk("t4_tick_16", 32'(bus.pulse_out[3]), 32'd1);

      // Reset mid-count on all channels.
      cfg(0, 2, 1, 1'b0); cfg(1, 3, 0, 1'b1); cfg(2, 0, 0, 1'b0);
      bus.en = '1;
      steps(3);
      sys_rst = 1'b1;
      #1;
      model_reset();
      chk("t5_rst_pulse", 32'(bus.pulse_out), 32'd0);
      chk("t5_rst_busy", 32'(bus.busy), 32'd0);
      chk("t5_rst_done", 32'(bus.done), 32'd0);
      @(posedge clk);
      cyc++;
      #1;
      check_all();
      sys_rst = 1'b0;
      step();
      chk("t5_reload_busy", 32'(bus.busy), 32'hF);
      chk("t5_reload_pulse", 32'(bus.pulse_out), 32'd0);
      steps(6);

      // Random traffic, config changing freely.
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < NC; i++) begin
            if ($urandom_range(0, 19) == 0) bus.en[i] = ~bus.en[i];
            bus.restart[i] = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0)
               cfg(i, $urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         end
`ifdef PULSE_TRANSMITTER_TIMER_READBACK_EN
         bus.rd_sel = 2'($urandom_range(0, 3));
`endif
         step();
      end
      bus.restart = '0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
